// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_pkg
//  Description : Shared definitions for the parametrised true dual-port BRAM.
//                Holds the output-register and write-mode encodings, the
//                string-to-encoding helpers used when elaborating the mode
//                parameters, and an elaboration-time assertion macro.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef BRAM_PKG_MACROS
`define BRAM_PKG_MACROS
// Expands to a labelled generate branch that stops elaboration when the
// condition does not hold. The branch is pruned entirely for legal settings.
`define BRAM_ELAB_ASSERT(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end
`endif

package bram_pkg;

    // Output register stage encodings
    localparam logic       REG_NONE  = 1'b0;
    localparam logic       REG_OUT   = 1'b1;

    // Write-cycle read-data behaviour encodings
    localparam logic [1:0] WM_NORMAL = 2'd0;
    localparam logic [1:0] WM_WTHRU  = 2'd1;
    localparam logic [1:0] WM_RBW    = 2'd2;

    function automatic logic reg_mode_enc(input string mode);
        return (mode == "OUTREG") ? REG_OUT : REG_NONE;
    endfunction

    function automatic logic [1:0] write_mode_enc(input string mode);
        if (mode == "WRITETHROUGH") begin
            return WM_WTHRU;
        end
        if (mode == "READBEFOREWRITE") begin
            return WM_RBW;
        end
        return WM_NORMAL;
    endfunction

    function automatic bit reg_mode_legal(input string mode);
        return (mode == "NOREG") || (mode == "OUTREG");
    endfunction

    function automatic bit write_mode_legal(input string mode);
        return (mode == "NORMAL") || (mode == "WRITETHROUGH") ||
               (mode == "READBEFOREWRITE");
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_port_out.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_out
//  Description : Read-data path of one BRAM port. Selects the word returned
//                for the access (old word, merged new word, or nothing for a
//                NORMAL-mode write), registers it as the stage-1 result and
//                optionally adds a second output register. The valid flag
//                travels with the data; the data registers hold their value
//                when no new result arrives.
//  Ports       : clk, rst      clock and synchronous active-high reset
//                i_en          access enable (already gated by reset)
//                i_we          byte-lane write enables of this access
//                i_din         write data of this access
//                i_old         memory word at the access address before the edge
//                o_dout        read data
//                o_valid       o_dout carries a fresh result this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_out
    import bram_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         BYTE_WIDTH = 8,
    parameter int         NBYTES     = DATA_WIDTH / BYTE_WIDTH,
    parameter logic       REG_MODE   = REG_NONE,
    parameter logic [1:0] WRITE_MODE = WM_NORMAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [NBYTES-1:0]     i_we,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_old,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid
);

    logic                  w_is_write;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_s1_val_d;
    logic [DATA_WIDTH-1:0] w_s1_data_d;
    logic                  r_s1_val_q;
    logic [DATA_WIDTH-1:0] r_s1_data_q;

    always_comb begin
        w_is_write = |i_we;
        // Word as it will read after the write: written lanes from i_din,
        // untouched lanes from the old memory word. Equals i_old on a read.
        w_merged = i_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (i_we[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = i_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        w_word      = (WRITE_MODE == WM_WTHRU) ? w_merged : i_old;
        // NORMAL-mode writes produce no result; every other access does.
        w_s1_val_d  = i_en & (~w_is_write | (WRITE_MODE != WM_NORMAL));
        w_s1_data_d = w_s1_val_d ? w_word : r_s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_val_q  <= 1'b0;
            r_s1_data_q <= '0;
        end else begin
            r_s1_val_q  <= w_s1_val_d;
            r_s1_data_q <= w_s1_data_d;
        end
    end

    if (REG_MODE == REG_OUT) begin : g_outreg
        logic                  w_s2_val_d;
        logic [DATA_WIDTH-1:0] w_s2_data_d;
        logic                  r_s2_val_q;
        logic [DATA_WIDTH-1:0] r_s2_data_q;

        // Stage 2 only loads when stage 1 holds a valid result.
        always_comb begin
            w_s2_val_d  = r_s1_val_q;
            w_s2_data_d = r_s1_val_q ? r_s1_data_q : r_s2_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_val_q  <= 1'b0;
                r_s2_data_q <= '0;
            end else begin
                r_s2_val_q  <= w_s2_val_d;
                r_s2_data_q <= w_s2_data_d;
            end
        end

        assign o_dout  = r_s2_data_q;
        assign o_valid = r_s2_val_q;
    end else begin : g_noreg
        assign o_dout  = r_s1_data_q;
        assign o_valid = r_s1_val_q;
    end

endmodule

`default_nettype wire

// File: rtl/bram_tdp_param.sv
`default_nettype none
// ============================================================================
//  Module      : bram_tdp_param
//  Description : Parametrised inferred true dual-port block RAM on a single
//                clock, with byte-lane write enables, per-port write mode,
//                optional output register, read-valid tracking and a
//                same-address collision pulse.
//  Ports       : clk, rst                    clock, synchronous active-high reset
//                ena, wea, addra, dia        port A enable/lane enables/address/data
//                doa, vala                   port A read data and valid
//                enb, web, addrb, dib        port B enable/lane enables/address/data
//                dob, valb                   port B read data and valid
//                collision                   pulse, cycle after a same-address
//                                            access where at least one port writes
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_tdp_param
    import bram_pkg::*;
#(
    parameter int    DATA_WIDTH  = 8,
    parameter int    BYTE_WIDTH  = 8,
    parameter int    ADDR_WIDTH  = 13,
    parameter string REGMODE_A   = "NOREG",
    parameter string REGMODE_B   = "NOREG",
    parameter string WRITEMODE_A = "NORMAL",
    parameter string WRITEMODE_B = "NORMAL",
    parameter string INIT_FILE   = ""
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dia,
    output logic [DATA_WIDTH-1:0]            doa,
    output logic                             vala,
    input  logic                             enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    input  logic [DATA_WIDTH-1:0]            dib,
    output logic [DATA_WIDTH-1:0]            dob,
    output logic                             valb,
    output logic                             collision
);

    localparam int         C_NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int         C_DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic       C_REG_A  = reg_mode_enc(REGMODE_A);
    localparam logic       C_REG_B  = reg_mode_enc(REGMODE_B);
    localparam logic [1:0] C_WM_A   = write_mode_enc(WRITEMODE_A);
    localparam logic [1:0] C_WM_B   = write_mode_enc(WRITEMODE_B);

    `BRAM_ELAB_ASSERT(g_chk_width, (DATA_WIDTH % BYTE_WIDTH) == 0, "DATA_WIDTH must be a multiple of BYTE_WIDTH")
    `BRAM_ELAB_ASSERT(g_chk_reg_a, reg_mode_legal(REGMODE_A), "REGMODE_A must be NOREG or OUTREG")
    `BRAM_ELAB_ASSERT(g_chk_reg_b, reg_mode_legal(REGMODE_B), "REGMODE_B must be NOREG or OUTREG")
    `BRAM_ELAB_ASSERT(g_chk_wm_a, write_mode_legal(WRITEMODE_A), "WRITEMODE_A must be NORMAL, WRITETHROUGH or READBEFOREWRITE")
    `BRAM_ELAB_ASSERT(g_chk_wm_b, write_mode_legal(WRITEMODE_B), "WRITEMODE_B must be NORMAL, WRITETHROUGH or READBEFOREWRITE")

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];

    logic                  w_en_a;
    logic                  w_en_b;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic                  w_collision_d;
    logic                  r_collision_q;

    // Power-up contents; the synthesis tool folds this into the BRAM init data.
    initial begin
        for (int i = 0; i < C_DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    always_comb begin
        // Reset suppresses every access, including one in the middle of a burst.
        w_en_a  = ena & ~rst;
        w_en_b  = enb & ~rst;
        // Pre-edge words: each port reads the old contents even when the
        // other port writes the same address in this cycle.
        w_old_a = r_mem[addra];
        w_old_b = r_mem[addrb];
        w_collision_d = w_en_a & w_en_b & (addra == addrb) & ((|wea) | (|web));
    end

    // Both write ports share one process; port A is applied last so it wins
    // lanes enabled by both ports at the same address.
    always @(posedge clk) begin
        for (int i = 0; i < C_NBYTES; i++) begin
            if (w_en_b && web[i]) begin
                r_mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dib[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (w_en_a && wea[i]) begin
                r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dia[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision_q <= 1'b0;
        end else begin
            r_collision_q <= w_collision_d;
        end
    end

    assign collision = r_collision_q;

    bram_port_out #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NBYTES     (C_NBYTES),
        .REG_MODE   (C_REG_A),
        .WRITE_MODE (C_WM_A)
    ) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en_a),
        .i_we    (wea),
        .i_din   (dia),
        .i_old   (w_old_a),
        .o_dout  (doa),
        .o_valid (vala)
    );

    bram_port_out #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NBYTES     (C_NBYTES),
        .REG_MODE   (C_REG_B),
        .WRITE_MODE (C_WM_B)
    ) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en_b),
        .i_we    (web),
        .i_din   (dib),
        .i_old   (w_old_b),
        .o_dout  (dob),
        .o_valid (valb)
    );

endmodule

`default_nettype wire
